// File: rtl/aes_decrypt_top.sv
// -----------------------------------------------------------------------------
// aes_decrypt_top -- iterative AES-128 inverse cipher
//
// Expands the cipher key forward into an 11-entry round-key store, one round
// key per clock. It then applies the round keys in reverse order, one full
// inverse round per clock. The byte order and the start/ready handshake match
// the AES-128 encryptor, so the two blocks can be chained back to back.
//
// Byte b of a block sits at bits [127-8*b -: 8]. Blocks are column-major:
// byte b holds row (b % 4) of column (b / 4).
//
// Ports (aes_decrypt_top):
//   CLK    in   1    clock, all state on rising edge
//   reset  in   1    asynchronous active-low reset
//   start  in   1    operation request, sampled only in IDLE
//   in     in   128  ciphertext block
//   key    in   128  cipher key, sampled together with start
//   out    out  128  plaintext, valid while ready=1, held until next FINAL
//   ready  out  1    high from completion until the next accepted start
//   busy   out  1    high from accepted start until completion
//
// Leaf modules in this file, all purely combinational:
//   aes_sbox             forward S-box, one byte (key schedule SubWord)
//   aes_inv_sbox         inverse S-box, one byte
//   aes_inv_mix_columns  InvMixColumns over a full 128-bit block
// -----------------------------------------------------------------------------

package aes_gf_pkg;

   // GF(2^8) multiply, reduction polynomial x^8+x^4+x^3+x+1
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] sh;
      acc = 8'h00;
      sh  = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ sh;
         sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
      end
      return acc;
   endfunction

   // Multiplicative inverse as a^254. Zero maps to zero, as the S-box requires.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] res;
      logic [7:0] pw;
      res = 8'h01;
      pw  = a;
      for (int i = 1; i < 8; i++) begin
         pw  = gf_mul(pw, pw);
         res = gf_mul(res, pw);
      end
      return res;
   endfunction

endpackage

// -----------------------------------------------------------------------------
// aes_sbox -- forward S-box: affine transform of the GF inverse
//   a  in   8  input byte
//   y  out  8  substituted byte
// -----------------------------------------------------------------------------
module aes_sbox (
   input  logic [7:0] a,
   output logic [7:0] y
);
   import aes_gf_pkg::*;

   logic [7:0] s;

   assign s = gf_inv(a);
   assign y = s ^ {s[6:0], s[7]} ^ {s[5:0], s[7:6]} ^ {s[4:0], s[7:5]}
                ^ {s[3:0], s[7:4]} ^ 8'h63;
endmodule

// -----------------------------------------------------------------------------
// aes_inv_sbox -- inverse S-box: inverse affine transform, then GF inverse
//   a  in   8  input byte
//   y  out  8  substituted byte
// -----------------------------------------------------------------------------
module aes_inv_sbox (
   input  logic [7:0] a,
   output logic [7:0] y
);
   import aes_gf_pkg::*;

   logic [7:0] t;

   assign t = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
   assign y = gf_inv(t);
endmodule

// -----------------------------------------------------------------------------
// aes_inv_mix_columns -- InvMixColumns on all four columns
//   blk    in   128  input block
//   mixed  out  128  output block
// -----------------------------------------------------------------------------
module aes_inv_mix_columns (
   input  logic [127:0] blk,
   output logic [127:0] mixed
);
   import aes_gf_pkg::*;

   always_comb begin
      logic [7:0] a0, a1, a2, a3;
      mixed = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = blk[127-32*c    -: 8];
         a1 = blk[127-32*c-8  -: 8];
         a2 = blk[127-32*c-16 -: 8];
         a3 = blk[127-32*c-24 -: 8];
         mixed[127-32*c    -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b)
                                 ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
         mixed[127-32*c-8  -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e)
                                 ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
         mixed[127-32*c-16 -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09)
                                 ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
         mixed[127-32*c-24 -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d)
                                 ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
      end
   end
endmodule

// -----------------------------------------------------------------------------
// aes_decrypt_top
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start; out/ready hold the last result
// KEYEXP | forward key expansion, rk[cnt] generated for cnt = 1..NR
// INIT   | state = in ^ rk[NR], round counter loaded with NR-1
// ROUND  | one inverse round with rk[cnt], cnt counting down to 1
// FINAL  | last round without InvMixColumns, result to out, ready set
// -----------------------------------------------------------------------------
module aes_decrypt_top #(
   parameter bit KEY_CACHE = 1'b1,
   parameter int NR        = 10
) (
   input  logic         CLK,
   input  logic         reset,
   input  logic         start,
   input  logic [127:0] in,
   input  logic [127:0] key,
   output logic [127:0] out,
   output logic         ready,
   output logic         busy
);

   localparam int CW = 4;

   typedef enum logic [2:0] {IDLE, KEYEXP, INIT, ROUND, FINAL} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q;
   logic          cache_vld_q;
   logic [127:0]  in_q;
   logic [127:0]  kexp_q;
   logic [127:0]  st_q;
   logic [127:0]  rk_q [0:NR];

   logic          cache_hit;
   logic [7:0]    rcon;
   logic [31:0]   rot_w, sub_w, temp_w;
   logic [31:0]   w0_n, w1_n, w2_n, w3_n;
   logic [127:0]  kexp_next;
   logic [127:0]  isr, isb, rk_sel, round_out;

   // rk_q[0] always holds the key of the last expansion, so it doubles as
   // the cached key; the valid flag only rises once rk[NR] has been written.
   assign cache_hit = KEY_CACHE && cache_vld_q && (key == rk_q[0]);

   // ---------------- key schedule ----------------
   always_comb begin
      rcon = 8'h00;
      case (cnt_q)
         4'd1:    rcon = 8'h01;
         4'd2:    rcon = 8'h02;
         4'd3:    rcon = 8'h04;
         4'd4:    rcon = 8'h08;
         4'd5:    rcon = 8'h10;
         4'd6:    rcon = 8'h20;
         4'd7:    rcon = 8'h40;
         4'd8:    rcon = 8'h80;
         4'd9:    rcon = 8'h1b;
         4'd10:   rcon = 8'h36;
         default: rcon = 8'h00;
      endcase
   end

   assign rot_w = {kexp_q[23:0], kexp_q[31:24]};

   genvar g;
   generate
      for (g = 0; g < 4; g++) begin : g_subword
         aes_sbox u_sbox (
            .a (rot_w[31-8*g -: 8]),
            .y (sub_w[31-8*g -: 8])
         );
      end
   endgenerate

   assign temp_w    = sub_w ^ {rcon, 24'h000000};
   assign w0_n      = kexp_q[127:96] ^ temp_w;
   assign w1_n      = kexp_q[95:64]  ^ w0_n;
   assign w2_n      = kexp_q[63:32]  ^ w1_n;
   assign w3_n      = kexp_q[31:0]   ^ w2_n;
   assign kexp_next = {w0_n, w1_n, w2_n, w3_n};

   // ---------------- inverse round datapath ----------------
   // Row r of every column rotates right by r columns: the byte landing in
   // column c comes from column (c - r) mod 4.
   always_comb begin
      isr = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            isr[127-8*(4*c+r) -: 8] = st_q[127-8*(4*((c-r+4)%4)+r) -: 8];
         end
      end
   end

   generate
      for (g = 0; g < 16; g++) begin : g_invsub
         aes_inv_sbox u_inv_sbox (
            .a (isr[127-8*g -: 8]),
            .y (isb[127-8*g -: 8])
         );
      end
   endgenerate

   assign rk_sel = rk_q[cnt_q];

   aes_inv_mix_columns u_inv_mix (
      .blk   (isb ^ rk_sel),
      .mixed (round_out)
   );

   // ---------------- FSM ----------------
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = cache_hit ? INIT : KEYEXP;
         KEYEXP:  if (cnt_q == CW'(NR)) state_d = INIT;
         INIT:    state_d = ROUND;
         ROUND:   if (cnt_q == CW'(1)) state_d = FINAL;
         FINAL:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         cnt_q       <= '0;
         cache_vld_q <= 1'b0;
         in_q        <= '0;
         kexp_q      <= '0;
         st_q        <= '0;
         out         <= '0;
         ready       <= 1'b0;
         busy        <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  in_q  <= in;
                  ready <= 1'b0;
                  busy  <= 1'b1;
                  if (!cache_hit) begin
                     kexp_q      <= key;
                     cache_vld_q <= 1'b0;
                     cnt_q       <= CW'(1);
                  end
               end
            end
            KEYEXP: begin
               kexp_q <= kexp_next;
               cnt_q  <= cnt_q + CW'(1);
               if (cnt_q == CW'(NR)) cache_vld_q <= 1'b1;
            end
            INIT: begin
               st_q  <= in_q ^ rk_q[NR];
               cnt_q <= CW'(NR - 1);
            end
            ROUND: begin
               st_q  <= round_out;
               cnt_q <= cnt_q - CW'(1);
            end
            FINAL: begin
               out   <= isb ^ rk_q[0];
               ready <= 1'b1;
               busy  <= 1'b0;
               cnt_q <= '0;
            end
            default: ;
         endcase
      end
   end

   // Round-key store carries no reset; its contents are only trusted once
   // cache_vld_q or the running operation has rewritten them.
   always_ff @(posedge CLK) begin
      if (state_q == IDLE && start && !cache_hit) rk_q[0] <= key;
      else if (state_q == KEYEXP)                 rk_q[cnt_q] <= kexp_next;
   end

endmodule

// File: tb/tb_aes_decrypt_top.sv
// -----------------------------------------------------------------------------
// tb_aes_decrypt_top -- bench for aes_decrypt_top
//
// Two instances share all inputs: u_dut with the key cache enabled and
// u_dut_nc with it disabled. A reference model holds table-driven AES
// encrypt/decrypt functions. It also holds a per-instance operation tracker
// giving the expected out/ready/busy on every cycle. Directed operations pin
// FIPS-197 vectors, latencies, ignored starts, mid-operation reset and a
// random loopback through the model encryptor.
// -----------------------------------------------------------------------------
module tb_aes_decrypt_top;

   logic         CLK   = 1'b0;
   logic         reset = 1'b0;
   logic         start = 1'b0;
   logic [127:0] din   = '0;
   logic [127:0] dkey  = '0;
   logic [127:0] out_c, out_nc;
   logic         ready_c, ready_nc, busy_c, busy_nc;

   int total = 0;
   int bad   = 0;

   always #5 CLK = ~CLK;

   aes_decrypt_top u_dut (
      .CLK   (CLK),
      .reset (reset),
      .start (start),
      .in    (din),
      .key   (dkey),
      .out   (out_c),
      .ready (ready_c),
      .busy  (busy_c)
   );

   aes_decrypt_top #(.KEY_CACHE(1'b0)) u_dut_nc (
      .CLK   (CLK),
      .reset (reset),
      .start (start),
      .in    (din),
      .key   (dkey),
      .out   (out_nc),
      .ready (ready_nc),
      .busy  (busy_nc)
   );

   // ---------------- reference AES ----------------
   logic [7:0] sb  [256];
   logic [7:0] isb [256];

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc, sh;
      acc = 8'h00;
      sh  = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ sh;
         sh = xt(sh);
      end
      return acc;
   endfunction

   // S-box generated by walking generator 3 and its inverse 3^-1 together
   initial begin
      logic [7:0] p, q, x;
      p = 8'h01;
      q = 8'h01;
      do begin
         p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
         q = q ^ {q[6:0], 1'b0};
         q = q ^ {q[5:0], 2'b00};
         q = q ^ {q[3:0], 4'h0};
         if (q[7]) q = q ^ 8'h09;
         x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
         sb[p] = x ^ 8'h63;
      end while (p != 8'h01);
      sb[0] = 8'h63;
      for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);
   end

   function automatic logic [127:0] rkey(input logic [127:0] k, input int r);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc;
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t  = {t[23:0], t[31:24]};
            t  = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
            rc = xt(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endfunction

   function automatic logic [127:0] model_enc(input logic [127:0] k, input logic [127:0] p);
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [127:0] v;
      v = p ^ rkey(k, 0);
      for (int r = 1; r <= 10; r++) begin
         for (int b = 0; b < 16; b++) s[b] = sb[v[127-8*b -: 8]];
         for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++) t[w+4*c] = s[w+4*((c+w)%4)];
         if (r < 10) begin
            for (int c = 0; c < 4; c++) begin
               s[4*c]   = mul(t[4*c],2) ^ mul(t[4*c+1],3) ^ t[4*c+2] ^ t[4*c+3];
               s[4*c+1] = t[4*c] ^ mul(t[4*c+1],2) ^ mul(t[4*c+2],3) ^ t[4*c+3];
               s[4*c+2] = t[4*c] ^ t[4*c+1] ^ mul(t[4*c+2],2) ^ mul(t[4*c+3],3);
               s[4*c+3] = mul(t[4*c],3) ^ t[4*c+1] ^ t[4*c+2] ^ mul(t[4*c+3],2);
            end
         end else begin
            for (int b = 0; b < 16; b++) s[b] = t[b];
         end
         for (int b = 0; b < 16; b++) v[127-8*b -: 8] = s[b];
         v = v ^ rkey(k, r);
      end
      return v;
   endfunction

   function automatic logic [127:0] model_dec(input logic [127:0] k, input logic [127:0] ct);
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [127:0] v;
      v = ct ^ rkey(k, 10);
      for (int r = 9; r >= 0; r--) begin
         for (int b = 0; b < 16; b++) s[b] = v[127-8*b -: 8];
         // undo the forward move of column c to column c-w
         for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++) t[w+4*((c+w)%4)] = isb[s[w+4*c]];
         for (int b = 0; b < 16; b++) v[127-8*b -: 8] = t[b];
         v = v ^ rkey(k, r);
         if (r > 0) begin
            for (int b = 0; b < 16; b++) t[b] = v[127-8*b -: 8];
            for (int c = 0; c < 4; c++) begin
               s[4*c]   = mul(t[4*c],14) ^ mul(t[4*c+1],11) ^ mul(t[4*c+2],13) ^ mul(t[4*c+3],9);
               s[4*c+1] = mul(t[4*c],9)  ^ mul(t[4*c+1],14) ^ mul(t[4*c+2],11) ^ mul(t[4*c+3],13);
               s[4*c+2] = mul(t[4*c],13) ^ mul(t[4*c+1],9)  ^ mul(t[4*c+2],14) ^ mul(t[4*c+3],11);
               s[4*c+3] = mul(t[4*c],11) ^ mul(t[4*c+1],13) ^ mul(t[4*c+2],9)  ^ mul(t[4*c+3],14);
            end
            for (int b = 0; b < 16; b++) v[127-8*b -: 8] = s[b];
         end
      end
      return v;
   endfunction

   // ---------------- per-instance operation tracker ----------------
   // index 0: cache enabled, index 1: cache disabled
   logic         m_busy  [2] = '{1'b0, 1'b0};
   logic         m_ready [2] = '{1'b0, 1'b0};
   logic [127:0] m_out   [2] = '{128'h0, 128'h0};
   logic [127:0] m_pend  [2];
   logic [127:0] m_ck    [2];
   bit           m_cv    [2] = '{1'b0, 1'b0};
   int           m_rem   [2];

   always @(posedge CLK or negedge reset) begin : model
      bit hit;
      for (int i = 0; i < 2; i++) begin
         if (!reset) begin
            m_busy[i]  = 1'b0;
            m_ready[i] = 1'b0;
            m_out[i]   = '0;
            m_cv[i]    = 1'b0;
            m_rem[i]   = 0;
         end else if (m_busy[i]) begin
            m_rem[i] = m_rem[i] - 1;
            if (m_rem[i] == 0) begin
               m_busy[i]  = 1'b0;
               m_ready[i] = 1'b1;
               m_out[i]   = m_pend[i];
               m_cv[i]    = 1'b1;
            end
         end else if (start) begin
            hit        = (i == 0) && m_cv[i] && (dkey == m_ck[i]);
            m_rem[i]   = hit ? 11 : 21;
            m_busy[i]  = 1'b1;
            m_ready[i] = 1'b0;
            m_pend[i]  = model_dec(dkey, din);
            if (!hit) begin
               m_ck[i] = dkey;
               m_cv[i] = 1'b0;
            end
         end
      end
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge CLK) begin
      check("out_cache",    out_c,    m_out[0]);
      check("ready_cache",  128'(ready_c),  128'(m_ready[0]));
      check("busy_cache",   128'(busy_c),   128'(m_busy[0]));
      check("out_nocache",  out_nc,   m_out[1]);
      check("ready_nocache",128'(ready_nc), 128'(m_ready[1]));
      check("busy_nocache", 128'(busy_nc),  128'(m_busy[1]));
   end

   // ---------------- directed stimulus ----------------
   localparam logic [127:0] C1_K = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] C1_P = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] B_K  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_C  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] B_P  = 128'h3243f6a8885a308d313198a2e0370734;

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic wait_idle(input string name);
      int g = 0;
      while ((busy_c || busy_nc) && g < 100) begin
         @(posedge CLK); #1;
         g++;
      end
      check({name, "_idle_timeout"}, 128'(g < 100), 128'(1));
   endtask

   task automatic run_op(input logic [127:0] k, input logic [127:0] c, input logic [127:0] exp,
                         input int lat, input int sel, input string name);
      int n = 0;
      wait_idle(name);
      dkey  = k;
      din   = c;
      start = 1'b1;
      @(posedge CLK); #1;
      start = 1'b0;
      dkey  = rnd128();
      din   = rnd128();
      while (!(sel == 1 ? ready_nc : ready_c) && n < 60) begin
         @(posedge CLK); #1;
         n++;
      end
      check({name, "_latency"}, 128'(n), 128'(lat));
      check({name, "_out"}, (sel == 1) ? out_nc : out_c, exp);
   endtask

   initial begin
      int n, busy_cnt;
      logic [127:0] k, p;

      // model pinned against FIPS-197 vectors
      #1;
      check("model_dec_c1", model_dec(C1_K, C1_C), C1_P);
      check("model_enc_b",  model_enc(B_K, B_P),  B_C);

      repeat (3) @(posedge CLK);
      #1;
      check("rst_out",   out_c,           128'h0);
      check("rst_ready", 128'(ready_c),   128'h0);
      check("rst_busy",  128'(busy_c),    128'h0);
      @(negedge CLK) reset = 1'b1;
      @(posedge CLK); #1;

      run_op(C1_K, C1_C, C1_P, 21, 0, "c1");
      run_op(B_K,  B_C,  B_P,  21, 0, "appb");
      run_op(B_K,  B_C,  B_P,  11, 0, "appb_hit");
      run_op(B_K,  B_C,  B_P,  21, 1, "appb_nocache");

      // starts during an operation are ignored
      wait_idle("pulse");
      dkey  = C1_K;
      din   = C1_C;
      start = 1'b1;
      @(posedge CLK); #1;
      start = 1'b0;
      n = 0;
      busy_cnt = 0;
      while (!ready_c && n < 60) begin
         @(posedge CLK); #1;
         n++;
         if (busy_c) busy_cnt++;
         if (n == 5 || n == 12) begin
            start = 1'b1;
            din   = rnd128();
         end else begin
            start = 1'b0;
         end
      end
      check("pulse_latency", 128'(n), 128'(21));
      check("pulse_busy_cycles", 128'(busy_cnt), 128'(20));
      check("pulse_out", out_c, C1_P);
      repeat (3) @(posedge CLK);
      #1;
      check("pulse_no_restart", 128'(busy_c), 128'h0);
      check("pulse_ready_held", 128'(ready_c), 128'h1);

      // reset in the middle of a cache-hit operation
      wait_idle("rst_mid");
      dkey  = C1_K;
      din   = C1_C;
      start = 1'b1;
      @(posedge CLK); #1;
      start = 1'b0;
      repeat (8) begin
         @(posedge CLK); #1;
      end
      check("rst_mid_busy_before", 128'(busy_c), 128'h1);
      reset = 1'b0;
      #1;
      check("rst_mid_out",   out_c,         128'h0);
      check("rst_mid_ready", 128'(ready_c), 128'h0);
      check("rst_mid_busy",  128'(busy_c),  128'h0);
      check("rst_mid_out_nc",out_nc,        128'h0);
      @(negedge CLK) reset = 1'b1;
      @(posedge CLK); #1;
      run_op(C1_K, C1_C, C1_P, 21, 0, "post_reset");

      // loopback through the model encryptor
      for (int i = 0; i < 100; i++) begin
         k = rnd128();
         p = rnd128();
         run_op(k, model_enc(k, p), p, 21, 0, "loopback");
      end

      wait_idle("end");
      @(posedge CLK); #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      bad++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "time limit");
   end

endmodule

// File: doc/aes_decrypt_top.md
Name: aes_decrypt_top

Overview:
Iterative AES-128 inverse cipher (FIPS-197 Sec. 5.3), the receive-side counterpart of the team's AES-128 encryptor. Expands the cipher key forward into an internal 11-entry round-key store, then applies round keys in reverse order, one full inverse round per clock. Byte ordering and start/ready handshake match the encryptor, so the two blocks can be chained in a loopback path.

Parameters:
KEY_CACHE, 1, when 1 skip key expansion if key equals the last fully expanded key; when 0 always expand.
NR, 10, number of rounds; fixed at 10 for AES-128, other values unsupported.

Ports:
CLK  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  request; sampled only in IDLE
in  in  128  ciphertext block; byte 0 = in[127:120], column-major (bits [127:96] = column 0)
key  in  128  AES-128 cipher key, same byte order; sampled with start
out  out  128  plaintext; valid while ready=1
ready  out  1  high from completion until the next accepted start
busy  out  1  high from accepted start until completion

Behaviour:
- Reset (reset=0, async): state=IDLE, out=0, ready=0, busy=0, round counter=0, key-cache valid flag=0, round-key store contents don't-care.
- Submodules: existing forward SBox (key schedule SubWord, 4 bytes/cycle); new combinational InvSBox and InvMixColumns leaves, 16 bytes/cycle. Both are pure combinational.
- FSM states: IDLE, KEYEXP, INIT, ROUND, FINAL.
- IDLE: on start=1, latch in and key, drop ready, set busy. Next state is INIT if KEY_CACHE=1, cache valid, and key equals the cached key. Otherwise KEYEXP with rk0=key and the valid flag cleared. start=0 leaves all outputs unchanged.
- KEYEXP: one round key per cycle, rk[i] from rk[i-1] (RotWord, SubWord, Rcon 01,02,04,08,10,20,40,80,1b,36). Runs 10 cycles (i=1..10). After rk10, set cache valid and go to INIT.
- INIT, 1 cycle: state = in ^ rk10; round counter = 9.
- ROUND, 1 cycle per round for r=9 down to 1: state = InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk[r]). Decrement counter; go to FINAL after r=1.
- FINAL, 1 cycle: out = InvSubBytes(InvShiftRows(state)) ^ rk0; ready=1, busy=0; go to IDLE.
- InvShiftRows: row k (byte k of each column) rotates right by k columns. Exact inverse of the encryptor's ShiftRows mapping.
- Latency, counted from the edge that samples start to the edge that sets ready: 21 cycles with key expansion, 11 cycles on a cache hit.
- start while busy: ignored, with no effect on in, key, or results.
- start held high across completion: a new operation is accepted on the first IDLE cycle after FINAL. ready drops on that acceptance edge.
- out holds the last result until reset or the next FINAL. It is not cleared on start.
- Reset mid-operation: immediate abort, all outputs at reset values, cache invalidated. No partial result is ever presented.
- in and key may change after the accepting edge without affecting the result.

Test Plan:
- FIPS-197 C.1: key=000102030405060708090a0b0c0d0e0f, in=69c4e0d86a7b0430d8cdb78070b4c55a -> out=00112233445566778899aabbccddeeff, ready rises exactly 21 cycles after start.
- FIPS-197 App. B: key=2b7e151628aed2a6abf7158809cf4f3c, in=3925841d02dc09fbdc118597196a0b32 -> out=3243f6a8885a308d313198a2e0370734.
- Cache hit: repeat the App. B decrypt with the same key and KEY_CACHE=1 -> same out, ready after 11 cycles. With KEY_CACHE=0 -> 21 cycles.
- start pulsed at cycles 5 and 12 of an operation, with different in -> ignored; out equals the first block's plaintext. busy stays high continuously.
- reset asserted at cycle 8 of an operation -> out=0, ready=0, busy=0 immediately. The next same-key operation takes 21 cycles (cache invalid).
- Loopback: 100 random key/plaintext pairs encrypted by the AES encryptor, then fed here -> out equals the original plaintext every time.
